// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte push handshake between a producer and the buffered UART transmitter
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter with sticky overflow flag
module uart_tx_fifo #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_fifo_if.slave          bus,
    output logic                   tx,
    output logic                   tx_active,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               tx_q, tx_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level, level_nxt;
    logic               busy_q;
    logic               overflow_q;
    logic [7:0]         mem [DEPTH];
    logic [1:0]         rst_sync;
    logic               run;
    logic               full, have_data, push_req, push_ok, drop, pop, bit_end;

    // Release from reset is retimed through two flops; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run       = rst_sync[1];
    assign full      = (level == LVL_FULL);
    assign have_data = (level != '0);
    assign push_req  = bus.tx_valid & run;
    assign push_ok   = push_req & ~full;
    // A full FIFO drops the byte even when a pop frees a slot in the same cycle.
    assign drop      = push_req & full;
    assign bit_end   = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.tx_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        pop       = 1'b0;
        tx_nxt    = 1'b1;

        case (state)
            S_IDLE: begin
                if (run && have_data) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    cnt_nxt   = '0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                    state_nxt = S_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    // Chain straight into the next start bit so a burst has no idle gap.
                    if (have_data) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        case (state_nxt)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_comb begin
        level_nxt = level;
        case ({push_ok, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            shift <= 8'h00;
            tx_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
            tx_q  <= tx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level  <= level_nxt;
            busy_q <= (level_nxt == LVL_FULL);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign tx          = tx_q;
    assign tx_active   = (state != S_IDLE) || have_data;
    assign fifo_level  = level;
    assign overflow    = overflow_q;
    assign bus.tx_busy = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo at DIV=10, DEPTH=4
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx;
    logic       tx_active;
    logic       overflow;
    logic [2:0] fifo_level;

    uart_tx_fifo_if bus_if ();

    uart_tx_fifo #(
        .CLK_HZ(1000000),
        .BAUD  (100000),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .tx        (tx),
        .tx_active (tx_active),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs[4];
    int         checks = 0;
    int         errors = 0;
    int         frame_errs = 0;
    logic [7:0] rx_q[$];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return {24'h0, rx_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check_rx_seq(input string name, input logic [7:0] first, input int n);
        check({name, " count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte%0d", name, i), rx_at(i), {24'h0, first + 8'(i)});
        end
    endtask

    // Entered on the first cycle of the start bit; leaves on the first cycle after the stop bit.
    task automatic check_frame(input string name, input logic [9:0] frame);
        for (int i = 0; i < 10; i++) begin
            cyc(i == 0 ? 5 : 10);
            check($sformatf("%s slot%0d", name, i), {31'h0, tx}, {31'h0, frame[i]});
        end
        cyc(4);
        check({name, " last stop cycle active"}, {31'h0, tx_active}, 32'h1);
        cyc(1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (tx_active !== 1'b0 && n < limit) begin
            cyc(1);
            n++;
        end
        check({name, " idle within bound"}, {31'h0, tx_active}, 32'h0);
    endtask

    task automatic push(input logic [7:0] d);
        bus_if.tx_data  = d;
        bus_if.tx_valid = 1'b1;
        cyc(1);
        bus_if.tx_valid = 1'b0;
    endtask

    // Line decoder: detects the start bit at its first cycle and samples every slot mid-bit.
    initial begin : rx_monitor
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                cyc(5);
                for (int i = 0; i < 8; i++) begin
                    cyc(10);
                    b[i] = tx;
                end
                cyc(10);
                if (tx !== 1'b1) frame_errs++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int sent;
        int guard;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        vecs[0] = '{8'h55, 10'h2AA};
        vecs[1] = '{8'hA5, 10'h34A};
        vecs[2] = '{8'h00, 10'h200};
        vecs[3] = '{8'hFF, 10'h3FE};

        cyc(3);
        check("reset tx", {31'h0, tx}, 32'h1);
        check("reset busy", {31'h0, bus_if.tx_busy}, 32'h0);
        check("reset active", {31'h0, tx_active}, 32'h0);
        check("reset level", {29'h0, fifo_level}, 32'h0);
        check("reset overflow", {31'h0, overflow}, 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Single-byte frames; vector 0 is pushed exactly two cycles after release.
        for (int v = 0; v < 4; v++) begin
            check($sformatf("v%0d idle line", v), {31'h0, tx}, 32'h1);
            push(vecs[v].data);
            check($sformatf("v%0d level N+1", v), {29'h0, fifo_level}, 32'h1);
            check($sformatf("v%0d tx N+1", v), {31'h0, tx}, 32'h1);
            cyc(1);
            check($sformatf("v%0d tx N+2", v), {31'h0, tx}, 32'h0);
            check($sformatf("v%0d level N+2", v), {29'h0, fifo_level}, 32'h0);
            check_frame($sformatf("v%0d", v), vecs[v].frame);
            check($sformatf("v%0d active after 100", v), {31'h0, tx_active}, 32'h0);
            check($sformatf("v%0d line after 100", v), {31'h0, tx}, 32'h1);
            cyc(3);
        end

        // Back-to-back: second push coincides with the first pop.
        rx_q.delete();
        bus_if.tx_data  = 8'h41;
        bus_if.tx_valid = 1'b1;
        cyc(1);
        check("b2b level N+1", {29'h0, fifo_level}, 32'h1);
        bus_if.tx_data = 8'h0D;
        cyc(1);
        bus_if.tx_valid = 1'b0;
        check("b2b level N+2", {29'h0, fifo_level}, 32'h1);
        check("b2b tx N+2", {31'h0, tx}, 32'h0);
        check_frame("b2b0", 10'h282);
        check("b2b second start", {31'h0, tx}, 32'h0);
        check("b2b level after pop2", {29'h0, fifo_level}, 32'h0);
        check_frame("b2b1", 10'h21A);
        check("b2b active after 200", {31'h0, tx_active}, 32'h0);
        check("b2b rx count", rx_q.size(), 2);
        check("b2b rx0", rx_at(0), 32'h41);
        check("b2b rx1", rx_at(1), 32'h0D);

        // Fill and overflow with six consecutive pushes.
        rx_q.delete();
        for (int k = 0; k < 6; k++) begin
            bus_if.tx_data  = 8'h30 + 8'(k);
            bus_if.tx_valid = 1'b1;
            cyc(1);
            if (k == 3) begin
                check("fill level3", {29'h0, fifo_level}, 32'h3);
                check("fill busy at 3", {31'h0, bus_if.tx_busy}, 32'h0);
            end
            if (k == 4) begin
                check("fill level4", {29'h0, fifo_level}, 32'h4);
                check("fill busy at 4", {31'h0, bus_if.tx_busy}, 32'h1);
                check("fill overflow before drop", {31'h0, overflow}, 32'h0);
            end
        end
        bus_if.tx_valid = 1'b0;
        check("fill overflow set", {31'h0, overflow}, 32'h1);
        check("fill level after drop", {29'h0, fifo_level}, 32'h4);
        wait_idle("fill", 800);
        check("fill overflow sticky", {31'h0, overflow}, 32'h1);
        check_rx_seq("fill rx", 8'h30, 5);

        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        check("overflow cleared by reset", {31'h0, overflow}, 32'h0);

        // Wrap-around stream, producer honours tx_busy.
        rx_q.delete();
        sent  = 0;
        guard = 0;
        while (sent < 12 && guard < 3000) begin
            if (bus_if.tx_busy === 1'b0) begin
                bus_if.tx_data  = 8'(sent);
                bus_if.tx_valid = 1'b1;
                sent++;
            end else begin
                bus_if.tx_valid = 1'b0;
            end
            cyc(1);
            guard++;
        end
        bus_if.tx_valid = 1'b0;
        check("wrap all pushed", sent, 12);
        wait_idle("wrap", 2000);
        check("wrap overflow", {31'h0, overflow}, 32'h0);
        check_rx_seq("wrap rx", 8'h00, 12);

        // Reset during data bit 3 of 0x00.
        push(8'h00);
        cyc(1);
        cyc(45);
        check("midreset line before", {31'h0, tx}, 32'h0);
        check("midreset active before", {31'h0, tx_active}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midreset tx async", {31'h0, tx}, 32'h1);
        check("midreset level", {29'h0, fifo_level}, 32'h0);
        check("midreset active", {31'h0, tx_active}, 32'h0);
        check("midreset busy", {31'h0, bus_if.tx_busy}, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        cyc(120);
        rx_q.delete();
        push(8'hA5);
        cyc(1);
        check("post reset start", {31'h0, tx}, 32'h0);
        check_frame("post reset A5", 10'h34A);
        check("post reset idle", {31'h0, tx_active}, 32'h0);
        check("post reset rx count", rx_q.size(), 1);
        check("post reset rx", rx_at(0), 32'hA5);

        // Push into a full FIFO on the cycle the STOP-expiry pop happens.
        rx_q.delete();
        for (int k = 0; k < 5; k++) begin
            bus_if.tx_data  = 8'h10 + 8'(k);
            bus_if.tx_valid = 1'b1;
            cyc(1);
        end
        bus_if.tx_valid = 1'b0;
        check("coin level full", {29'h0, fifo_level}, 32'h4);
        cyc(96);
        check("coin level at stop end", {29'h0, fifo_level}, 32'h4);
        check("coin stop line", {31'h0, tx}, 32'h1);
        check("coin overflow before", {31'h0, overflow}, 32'h0);
        push(8'hEE);
        check("coin level after", {29'h0, fifo_level}, 32'h3);
        check("coin overflow after", {31'h0, overflow}, 32'h1);
        check("coin busy after", {31'h0, bus_if.tx_busy}, 32'h0);
        check("coin next start", {31'h0, tx}, 32'h0);
        wait_idle("coin", 800);
        check_rx_seq("coin rx", 8'h10, 5);

        check("stop bit errors", frame_errs, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
